com_async_fifo_wr_arb: RTL
==========================

# com_async_fifo_wr_arb

Packet-granular write-side arbiter for one async FIFO instance: shares the single FIFO write port among N requesters in the FIFO write clock domain. A packet is granted only when the FIFO's free-space count covers the whole packet, so granted packets stream without stalls under normal conditions. Round-robin fairness, with a starvation lock so long packets are not starved by short ones. Sits directly in front of the async FIFO write port (wr_en / wr_full / free-space level) and its data RAM write side.

## Interface
- N, 4: number of requesters, 2..16.
- DW, 32: data width per beat.
- DEPTH, 4: FIFO depth in entries; must equal the controlled FIFO's DEPTH.
- AW, $clog2((DEPTH>2?DEPTH:2)+1): width of fifo_space; must match the FIFO level port.
- LW, 8: packet length field width, in beats.
- STARVE_TH, 4: consecutive skipped arbitrations before a requester locks priority, 1..15.

- clk  in  1  FIFO write-side clock. Single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  while high, no new grant; an in-progress packet completes.
- req_vld  in  N  requester i has a packet pending; held until its last beat is popped.
- req_len  in  N*LW  packet length of requester i, slice [i*LW+:LW], stable while req_vld; 0 treated as 1.
- req_data  in  N*DW  current beat of requester i, show-ahead, valid every cycle while granted.
- req_pop  out  N  one-hot; beat of requester i consumed this cycle.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DW  FIFO write data.
- fifo_wr_full  in  1  FIFO full.
- fifo_space  in  AW  FIFO free entries, write-domain view; may under-report, never over-report.
- grant_id  out  $clog2(N)  index of the granted requester, valid while busy.
- busy  out  1  packet transfer in progress.

## Operation
- FSM states: IDLE, XFER.
- IDLE, hold=0:
  - len_eff = max(req_len,1), zero-extended to max(LW,AW)+1 bits.
  - Requester i is eligible when req_vld[i] and (len_eff ≤ fifo_space, or len_eff > DEPTH and fifo_space == DEPTH).
  - Oversize packets wait for an empty FIFO, then stream under wr_full backpressure.
- Selection, in priority order:
  - Locked requester: it alone may be granted. No other grant while the lock is held, even if others are eligible.
  - Otherwise the first eligible requester searching from rr_ptr upward, modulo N.
- On grant: latch grant_id, set beat counter cnt = len_eff, go to XFER, busy=1.
  - Every requester with req_vld=1 that was passed over because it was ineligible increments its skip counter, saturating at STARVE_TH.
  - Counter reaching STARVE_TH locks that requester. If several reach it, the lowest index from rr_ptr wins; the others keep their count.
  - The granted requester's skip counter clears; its lock clears.
- IDLE with no eligible requester: no counter changes; stay IDLE.
- XFER:
  - fifo_wr_en = !fifo_wr_full.
  - req_pop[grant_id] = fifo_wr_en.
  - fifo_wr_data = req_data[grant_id].
  - Each write decrements cnt. The write with cnt==1 returns to IDLE, busy=0, rr_ptr = grant_id+1 mod N.
- hold asserted during XFER has no effect until the packet ends.
- req_vld dropping mid-packet is a protocol violation; the packet still completes its cnt beats.
- rst in any state: immediate return to IDLE. A partially written packet is abandoned; the FIFO is cleared separately by the system.

## Timing
- Reset values: fifo_wr_en=0, req_pop=0, fifo_wr_data=0 (IDLE drives 0), grant_id=0, busy=0, rr_ptr=0, all skip counters/locks 0.
- Arbitration: single cycle. req_vld sampled in cycle T (IDLE) → busy=1 and first fifo_wr_en in T+1, if !fifo_wr_full.
- fifo_wr_en, req_pop and fifo_wr_data are combinational from the registered state and fifo_wr_full; no extra latency.
- A packet of L beats with no full occupies L cycles in XFER. One IDLE bubble between back-to-back packets: packet throughput L/(L+1).
- fifo_wr_full high in XFER: the beat stalls, cnt holds, req_pop=0.
- fifo_space is sampled only in IDLE; a stale (low) value only delays grants.

## Test plan
- Reset/idle: rst=1 for 3 cycles with req_vld=4'b1111 → all outputs 0, busy=0; first grant is requester 0, first fifo_wr_en the cycle after rst drops.
- Round robin: N=4, DEPTH=8, all req_len=2, fifo_space held 8 → grant order 0,1,2,3,0; each packet gives 2 pops then 1 bubble.
- Space gating: fifo_space=3, req0 len=5, req1 len=2 → req1 granted first, req0 skip=1. Raise space to 5 → req0 granted.
- Starvation lock: STARVE_TH=2, req0 len=6 never fits, req1/req2 len=1 → after two skips req0 locks and no further grants. Space=6 → req0 granted; its 6 pops are contiguous.
- Oversize/backpressure: DEPTH=4, req2 len=10 → grant only at space=4. Force fifo_wr_full for 3 cycles mid-packet → exactly 10 pops total, no pop while full.
- Hold/reset: hold=1 mid-packet → packet completes, then no grant until hold=0. rst asserted mid-packet → next cycle busy=0, req_pop=0, rr_ptr=0.

Source files
------------

// File: rtl/com_async_fifo_wr_arb.sv
// com_async_fifo_wr_arb: packet-granular round-robin arbiter with starvation lock feeding one async FIFO write port (req_vld/len/data/pop per requester; fifo_wr_en/data/full/space; grant_id, busy)
module com_async_fifo_wr_arb #(
  parameter int N = 4,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter int AW = $clog2((DEPTH > 2 ? DEPTH : 2) + 1),
  parameter int LW = 8,
  parameter int STARVE_TH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [N-1:0]           req_vld,
  input  logic [N*LW-1:0]        req_len,
  input  logic [N*DW-1:0]        req_data,
  output logic [N-1:0]           req_pop,
  output logic                   fifo_wr_en,
  output logic [DW-1:0]          fifo_wr_data,
  input  logic                   fifo_wr_full,
  input  logic [AW-1:0]          fifo_space,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy
);
  localparam int IW = $clog2(N);
  localparam int LE = (LW > AW ? LW : AW) + 1;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, lock_id, sel, lsel;
  logic lock_vld, found, lfound;
  logic [LE-1:0] cnt;
  logic [LE-1:0] len_eff [N];
  logic [N-1:0] elig;
  logic [3:0] skip [N];
  logic [3:0] skip_n [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      len_eff[i] = (req_len[i*LW+:LW] == '0) ? LE'(1) : LE'(req_len[i*LW+:LW]);
      elig[i] = req_vld[i] && (len_eff[i] <= LE'(fifo_space) ||
                (len_eff[i] > LE'(DEPTH) && fifo_space == AW'(DEPTH)));
    end
  end
  always_comb begin
    found = lock_vld && elig[lock_id];
    sel = lock_vld ? lock_id : '0;
    for (int k = 0; k < N; k++)
      if (!lock_vld && !found && elig[(int'(rr_ptr) + k) % N]) begin
        found = 1'b1;
        sel = IW'((int'(rr_ptr) + k) % N);
      end
  end
  always_comb begin
    lfound = 1'b0;
    lsel = '0;
    for (int i = 0; i < N; i++)
      skip_n[i] = (IW'(i) == sel) ? 4'd0 :
                  (req_vld[i] && !elig[i] && skip[i] != 4'(STARVE_TH)) ? skip[i] + 4'd1 : skip[i];
    for (int k = 0; k < N; k++)
      if (!lfound && skip_n[(int'(rr_ptr) + k) % N] == 4'(STARVE_TH)) begin
        lfound = 1'b1;
        lsel = IW'((int'(rr_ptr) + k) % N);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      lock_vld <= 1'b0;
      lock_id <= '0;
      for (int i = 0; i < N; i++) skip[i] <= '0;
    end else if (state == IDLE) begin
      if (!hold && found) begin
        state <= XFER;
        grant_id <= sel;
        cnt <= len_eff[sel];
        skip <= skip_n;
        lock_vld <= lfound;
        lock_id <= lsel;
      end
    end else if (fifo_wr_en) begin
      if (cnt == LE'(1)) begin
        state <= IDLE;
        rr_ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign busy = state == XFER;
  assign fifo_wr_en = busy && !fifo_wr_full;
  assign req_pop = fifo_wr_en ? {{(N-1){1'b0}}, 1'b1} << grant_id : '0;
  assign fifo_wr_data = busy ? req_data[grant_id*DW+:DW] : '0;
endmodule
